// File: rtl/pp_column_serializer_pkg.sv
// pp_column_serializer_pkg: shared constants, FSM states and column-geometry helpers
package pp_pkg;
  localparam int N_DEFAULT = 13;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic int col_height(int i, int n);
    return (i + 1 < 2 * n - 1 - i) ? i + 1 : 2 * n - 1 - i;
  endfunction
  function automatic int col_jmin(int i, int n);
    return (i > n - 1) ? i - (n - 1) : 0;
  endfunction
endpackage

// File: rtl/pp_column_serializer_if.sv
// pp_column_serializer_if: operand handshake plus column-serial output bundle
interface pp_column_serializer_if #(parameter int N = pp_pkg::N_DEFAULT);
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_a;
  logic [N-1:0]      in_b;
  logic [2*N-2:0]    col_bit;
  logic              busy;
  logic              done;
  modport master (output in_valid, in_a, in_b, input in_ready, col_bit, busy, done);
  modport slave  (input in_valid, in_a, in_b, output in_ready, col_bit, busy, done);
endinterface

// File: rtl/pp_column_serializer_mux.sv
// pp_column_mux: selects element N-1-t of every partial-product column (zero above the column height)
module pp_column_mux
  import pp_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int COLS = 2 * N - 1,
  localparam int TW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [TW-1:0]   t,
  output logic [COLS-1:0] col
);
  logic [TW-1:0] sel;
  assign sel = TW'(N - 1) - t;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [N-1:0] el;
    for (genvar e = 0; e < N; e++) begin : g_el
      if (e < col_height(c, N)) begin : g_on
        assign el[e] = a[col_jmin(c, N) + e] & b[c - col_jmin(c, N) - e];
      end else begin : g_off
        assign el[e] = 1'b0;
      end
    end
    assign col[c] = el[sel];
  end
endmodule

// File: rtl/pp_column_serializer.sv
// pp_column_serializer: captures A/B and streams one bit per weight column for N cycles; PP_COLUMN_SERIALIZER_B2B_EN allows acceptance in DONE
module pp_column_serializer
  import pp_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic                    clk,
  input logic                    rst,
  pp_column_serializer_if.slave  bus
);
  localparam int COLS = 2 * N - 1;
  localparam int TW = N > 1 ? $clog2(N) : 1;
  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [COLS-1:0] col_q, col_d, col_nxt;
  logic            accept;
`ifdef PP_COLUMN_SERIALIZER_B2B_EN
  assign bus.in_ready = state_q != SHIFT;
`else
  assign bus.in_ready = state_q == IDLE;
`endif
  assign accept      = bus.in_valid & bus.in_ready;
  assign bus.busy    = state_q == SHIFT;
  assign bus.done    = state_q == DONE;
  assign bus.col_bit = col_q;
  pp_column_mux #(.N(N)) u_mux (.a(a_d), .b(b_d), .t(t_d), .col(col_nxt));
  // next state, counter and operand capture; col_d is precomputed from next-cycle values so col_bit is registered
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    if (accept) begin
      state_d = SHIFT;
      t_d     = '0;
      a_d     = bus.in_a;
      b_d     = bus.in_b;
    end else if (state_q == SHIFT) begin
      state_d = t_q == TW'(N - 1) ? DONE : SHIFT;
      t_d     = t_q == TW'(N - 1) ? '0 : t_q + 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    col_d = state_d == SHIFT ? col_nxt : '0;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      col_q   <= col_d;
    end
  end
endmodule

// File: tb/tb_pp_column_serializer.sv
// tb_pp_column_serializer: randomized and directed bench against a cycle-count reference model and a downstream shift-register model
module tb_pp_column_serializer;
  localparam int N = pp_pkg::N_DEFAULT;
  localparam int COLS = 2 * N - 1;
  localparam int IDLE_C = N + 2;
`ifdef PP_COLUMN_SERIALIZER_B2B_EN
  localparam bit B2B = 1'b1;
  localparam int SP = 14;
`else
  localparam bit B2B = 1'b0;
  localparam int SP = 15;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pp_column_serializer_if #(.N(N)) bus ();
  pp_column_serializer #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_err = 0;
  int cyc = IDLE_C;
  int cycle = 0;
  int acc_cycle = 0;
  int done_cnt = 0;
  bit acc = 1'b0;
  bit run = 1'b0;
  logic [N-1:0] ma = '0;
  logic [N-1:0] mb = '0;
  logic [N-1:0] sr [COLS];
  logic [63:0] last_dst = '0;
  logic [63:0] dst;
  function automatic bit ready_f(int c);
    return c >= IDLE_C || (B2B && c == N + 1);
  endfunction
  function automatic int depth(int i);
    int d;
    d = 0;
    for (int j = 0; j < N; j++) if (i - j >= 0 && i - j < N) d++;
    return d;
  endfunction
  function automatic logic [N-1:0] msk(int i);
    return N'((64'd1 << depth(i)) - 64'd1);
  endfunction
  function automatic logic [COLS-1:0] exp_col(logic [N-1:0] a, logic [N-1:0] b, int t);
    logic [COLS-1:0] v;
    int k;
    v = '0;
    for (int i = 0; i < COLS; i++) begin
      k = 0;
      for (int j = 0; j < N; j++) begin
        if (i - j >= 0 && i - j < N) begin
          if (k == N - 1 - t) v[i] = a[j] & b[i - j];
          k++;
        end
      end
    end
    return v;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask
  always @(posedge clk) begin
    cycle++;
    acc = 1'b0;
    run = 1'b1;
    if (rst) cyc = IDLE_C;
    else if (bus.in_valid && ready_f(cyc)) begin
      ma = bus.in_a;
      mb = bus.in_b;
      cyc = 1;
      acc = 1'b1;
      acc_cycle = cycle;
    end else if (cyc < IDLE_C) cyc++;
  end
  always @(negedge clk) if (run) begin
    chk("in_ready", 64'(bus.in_ready), 64'(ready_f(cyc)));
    chk("busy", 64'(bus.busy), 64'(cyc >= 1 && cyc <= N));
    chk("done", 64'(bus.done), 64'(cyc == N + 1));
    chk("col_bit", 64'(bus.col_bit), 64'((cyc >= 1 && cyc <= N) ? exp_col(ma, mb, cyc - 1) : '0));
    if (cyc == 1) for (int i = 0; i < COLS; i++) sr[i] = '0;
    if (cyc >= 1 && cyc <= N) for (int i = 0; i < COLS; i++) sr[i] = {sr[i][N-2:0], bus.col_bit[i]};
    if (cyc == N + 1) begin
      dst = '0;
      for (int i = 0; i < COLS; i++) dst += 64'($countones(sr[i] & msk(i))) << i;
      last_dst = dst;
      chk("product", dst, 64'(ma) * 64'(mb));
      done_cnt++;
    end
  end
  task automatic wait_acc();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      got = acc;
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
  endtask
  task automatic send(logic [N-1:0] a, logic [N-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    wait_acc();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      #1;
      got = done_cnt != d0;
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
  endtask
  task automatic wait_cyc(int c);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = cyc == c;
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL wait_cyc_timeout: got no phase %0d expected it within 60 cycles", c);
    end
    #1;
  endtask
  initial begin
    logic [N-1:0] ra, rb;
    int t0, t1, t2;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(13'h0001, 13'h0001);
    wait_done();
    chk("dst_1x1", last_dst, 64'd1);
    send(13'h0003, 13'h0005);
    wait_done();
    chk("dst_3x5", last_dst, 64'd15);
    send(13'h1FFF, 13'h1FFF);
    wait_done();
    chk("dst_max", last_dst, 64'h3FFC001);
    send(N'($urandom), N'($urandom));
    wait_cyc(6);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_col", 64'(bus.col_bit), 64'd0);
    ra = N'($urandom);
    rb = N'($urandom);
    send(ra, rb);
    wait_cyc(4);
    bus.in_a = ~ra;
    wait_done();
    chk("hold", last_dst, 64'(ra) * 64'(rb));
    bus.in_valid = 1'b1;
    bus.in_a = 13'h0123;
    bus.in_b = 13'h0456;
    wait_acc();
    t0 = acc_cycle;
    bus.in_a = 13'h1ABC;
    bus.in_b = 13'h0F0F;
    wait_acc();
    t1 = acc_cycle;
    bus.in_a = 13'h0777;
    bus.in_b = 13'h1001;
    wait_acc();
    t2 = acc_cycle;
    bus.in_valid = 1'b0;
    chk("spacing_1", 64'(t1 - t0), 64'(SP));
    chk("spacing_2", 64'(t2 - t1), 64'(SP));
    wait_done();
    for (int r = 0; r < 25; r++) begin
      send(N'($urandom), N'($urandom));
      for (int g = 0; g < int'($urandom_range(20, 0)); g++) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'($urandom);
        bus.in_a = N'($urandom);
        bus.in_b = N'($urandom);
      end
      bus.in_valid = 1'b0;
      wait_cyc(IDLE_C);
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pp_column_serializer.md
Name: pp_column_serializer

Overview:
- Upstream stage of the 13x13 multiplier compressor test path.
- Accepts one operand pair (A, B) through a valid/ready handshake and forms the AND partial-product array.
- Serialises each weight column into one bit per clock, one output bit per column, so the downstream per-column shift registers (depth = column height) hold the complete array after one burst.
- Pulses a done strobe on the cycle the compressor inputs are fully loaded and its outputs can be sampled.

Parameters:
- N, 13, operand width; burst length in cycles.
- COLS, 2*N-1 (derived, localparam), number of weight columns; column i height h(i) = min(i+1, 2N-1-i).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept operands
- in_a  in  N  multiplicand, unsigned
- in_b  in  N  multiplier, unsigned
- col_bit  out  COLS  bit i drives column i serial input (src{i}_ of shift register)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse: downstream array fully loaded

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, t=0, operand regs=0, col_bit=0, busy=0, done=0, in_ready=1 after reset. rst mid-burst aborts immediately; no done is emitted.
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures in_a/in_b, sets t=0, and moves to SHIFT.
  - SHIFT: in_ready=0, busy=1. t counts 0..N-1; at t=N-1 move to DONE.
  - DONE: one cycle, done=1, busy=0, then IDLE.
- Column element order:
  - jmin = max(0, i-(N-1)).
  - Element k of column i = a[jmin+k] & b[i-jmin-k], for k = 0..h(i)-1.
- Emission: in SHIFT cycle t, col_bit[i] = element (N-1-t) of column i when N-1-t < h(i), else 0.
  - Effect: each column emits leading zeros, then its elements from highest k down to k=0.
  - Element 0 is emitted at t=N-1 and lands in the shift-register LSB.
- col_bit is registered and driven only in SHIFT; it is 0 in IDLE and DONE.
- Latency: accept at edge E. SHIFT cycles occupy the N cycles after E. done is high in cycle N+1 after E.
- Operands are held stable in internal registers for the whole burst. in_a/in_b changes after acceptance are ignored.
- in_valid while not ready: no capture, and the value is not queued.
- Counter width = clog2(N). t never exceeds N-1.

Optional Feature:
- Macro: PP_COLUMN_SERIALIZER_B2B_EN.
- Defined: in_ready=1 also in DONE. A handshake in DONE goes directly to SHIFT with t=0 and the new operands, giving back-to-back bursts with a period of N+1 cycles. done still pulses in that DONE cycle.
- Undefined: DONE always returns to IDLE, and in_ready is high only in IDLE, giving a minimum period of N+2 cycles.

Decomposition:
- Shared package pp_pkg:
  - N_DEFAULT=13
  - col_height(i) and col_jmin(i) constant functions
  - state enum {IDLE, SHIFT, DONE}
- One natural sub-module: pp_column_mux.
  - Purely combinational.
  - Inputs: captured a, b, and t. Output: the COLS-wide bit vector for the current cycle.
  - The top module holds the FSM, counter and output register.

Test Plan:
- Reset: assert rst for 2 cycles mid-burst (t=5) -> next cycle col_bit=0, busy=0, no done; in_ready=1.
- a=0x0001, b=0x0001 -> col_bit=0 in all SHIFT cycles except t=12, where col_bit=0x0000001. done is high 14 cycles after acceptance. Downstream dst vector = 1.
- a=0x0003, b=0x0005:
  - t=11: col_bit[1]=1 (a1b0).
  - t=12: col_bit[0]=1 and col_bit[2]=1 (col2 k0: a0b2=1).
  - Downstream product = 15.
- a=b=0x1FFF -> col_bit[12]=1 in every SHIFT cycle; col_bit[24]=1 only at t=12. Downstream dst = 0x3FFC001.
- Handshake: hold in_valid high continuously with 3 distinct operand pairs.
  - Macro undefined: accepts spaced 15 cycles apart.
  - Macro defined: accepts spaced 14 cycles apart, the 2nd in the DONE cycle.
  - Each resulting product is checked.
- Operand hold: change in_a at t=3 of a burst -> emitted bits still reflect the captured value.
